lsu_unit: RTL
=============

Name: lsu_unit

Overview:
Load/store unit sitting directly downstream of the ALU in the execute path. It takes the ALU sum (rs1 + imm) as the effective address, checks alignment, and issues one word-aligned access to the data memory port with a byte mask. It returns sign- or zero-extended load data, or a fault, to writeback. It is a single-outstanding, multi-cycle unit with a valid/ready handshake on both sides and a bus timeout.

Parameters:
XLEN, 32, data and address width; must equal REG_END_WORD+1.
TIMEOUT, 255, maximum cycles to wait in REQ or WAIT before raising a bus fault; 0 disables the timeout.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  execute presents a memory op
req_ready  out  1  high only in IDLE
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  XLEN  effective address from ALU OP_ADD result
req_wdata  in  XLEN  rs2 value for stores
req_rd  in  5  destination register tag, returned unchanged
mem_req_valid  out  1  memory request strobe
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  {req_addr[XLEN-1:2], 2'b00}
mem_wen  out  1  write enable
mem_wmask  out  4  byte lanes written
mem_wdata  out  XLEN  store data replicated or shifted into the target lanes
mem_rvalid  in  1  read data or write-ack return, one cycle pulse
mem_rdata  in  XLEN  full aligned word
resp_valid  out  1  result available
resp_ready  in  1  writeback consumes the result
resp_data  out  XLEN  extended load data; 0 for stores and faults
resp_rd  out  5  latched req_rd
resp_fault  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3

Behaviour:
- Reset: state=IDLE, req_ready=1, mem_req_valid=0, mem_wen=0, mem_wmask=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_data=0, resp_rd=0, resp_fault=0, timeout counter=0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: on req_valid, latch all request fields.
  - If funct3 is illegal (011, 110, 111, or 100/101 on a store), go to RESP with fault 11.
  - Else if misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0), go to RESP with fault 01. No memory access is made.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1 with stable addr/wen/wmask/wdata. When mem_req_ready=1, go to WAIT. mem_rvalid in the same cycle as acceptance is legal and goes straight to RESP.
- WAIT: on mem_rvalid, capture and extend rdata, then go to RESP.
- Timeout: the counter clears on entering REQ and counts in REQ and WAIT. When it reaches TIMEOUT, go to RESP with fault 10, and mem_req_valid drops.
- RESP: resp_valid=1 and all resp_* fields are held stable until resp_ready=1, then go to IDLE. There is no req acceptance in the same cycle (1-cycle bubble).
- Minimum latency for a load with zero-wait memory: accepted at cycle 0, mem request at cycle 1, rvalid at cycle 1, resp_valid at cycle 2.
- Store mask and data:
  - SB: wmask = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wmask = 4'b0011 << addr[1:0], wdata = {2{wdata[15:0]}}.
  - SW: wmask = 4'b1111.
- Load extraction:
  - Byte = rdata >> (8*addr[1:0]); halfword = rdata >> (8*addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- A store completes on mem_rvalid (write ack) with resp_data=0.
- Stray mem_rvalid in IDLE or RESP is ignored.
- reset asserted in any state returns to IDLE on the next edge. An in-flight memory access is abandoned, and the memory side must tolerate a dropped mem_req_valid.
- All outputs are registered except req_ready, which decodes state.

Decomposition:
- Shared package (defs.vh alongside the OP_* codes):
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Fault encodings FAULT_NONE, FAULT_MISALIGN, FAULT_BUS, FAULT_ILLEGAL.
  - FSM state enum lsu_state_t.
- One combinational sub-module, lsu_align: given funct3, addr[1:0], wdata and rdata, it produces wmask, shifted wdata, extended load data and the misaligned/illegal flags. It is reused unchanged by the future cache refill path.

Test Plan:
- LB at addr 0x1003, mem word 0x80FF_1234, zero wait -> mem_addr 0x1000, wen 0; resp_valid at cycle 2, resp_data 0xFFFF_FF80, fault 00.
- SH at addr 0x2002, wdata 0x0000_BEEF -> mem_wmask 1100, mem_wdata 0xBEEF_BEEF, wen 1; after rvalid, resp_data 0, fault 00.
- LW at addr 0x3001 -> no mem_req_valid ever asserted; resp_valid one cycle after accept, fault 01, resp_rd echoes req_rd.
- LHU at addr 0x4002 with memory taking 5 cycles to grant and 3 to return rdata 0xA5A5_0000 -> mem fields stable throughout REQ; resp_data 0x0000_A5A5.
- TIMEOUT=8, memory never grants -> mem_req_valid drops after 8 cycles; resp_valid with fault 10; resp held for 4 cycles of resp_ready=0.
- reset pulsed while in WAIT -> next cycle req_ready=1 and mem_req_valid=0; a late mem_rvalid produces no resp_valid.

Source files
------------

// File: rtl/lsu_unit_pkg.sv
// Shared definitions for the load/store unit: width codes, fault codes, FSM states.
package lsu_unit_pkg;

    localparam int unsigned REG_END_WORD = 31;
    localparam int unsigned XLEN_DEF     = REG_END_WORD + 1;

    // RV32I load/store width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Response fault encodings
    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUS      = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_t;

    // Request attributes kept for the life of an access
    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } lsu_op_t;

    // Unsigned widths exist only for loads; 011/110/111 are never legal
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = is_store;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_unit_if.sv
// Request, data-memory and writeback response signals of the load/store unit.
interface lsu_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_is_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [4:0]      req_rd;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [3:0]      mem_wmask;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic [1:0]      resp_fault;

    // LSU side
    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output resp_valid, resp_data, resp_rd, resp_fault,
        input  resp_ready
    );

    // Execute / memory / writeback side
    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  resp_valid, resp_data, resp_rd, resp_fault,
        output resp_ready
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store mask/data placement, load extraction, legality flags.
module lsu_align
    import lsu_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wmask_c,
    output logic [XLEN-1:0] wdata_c,
    output logic [XLEN-1:0] rdata_c,
    output logic            misaligned_c,
    output logic            illegal_c
);

    logic [15:0] shifted;

    // Lane placement and extension per width code
    always_comb begin
        shifted      = 16'(rdata >> {addr_lo, 3'b000});
        wmask_c      = 4'b0000;
        wdata_c      = '0;
        rdata_c      = '0;
        misaligned_c = 1'b0;
        illegal_c    = f3_illegal(is_store, funct3);
        case (funct3)
            F3_B: begin
                wmask_c = 4'b0001 << addr_lo;
                wdata_c = XLEN'({4{wdata[7:0]}});
                rdata_c = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                rdata_c = {{(XLEN-8){1'b0}}, shifted[7:0]};
            end
            F3_H: begin
                misaligned_c = addr_lo[0];
                wmask_c      = 4'b0011 << addr_lo;
                wdata_c      = XLEN'({2{wdata[15:0]}});
                rdata_c      = {{(XLEN-16){shifted[15]}}, shifted};
            end
            F3_HU: begin
                misaligned_c = addr_lo[0];
                rdata_c      = {{(XLEN-16){1'b0}}, shifted};
            end
            F3_W: begin
                misaligned_c = (addr_lo != 2'b00);
                wmask_c      = 4'b1111;
                wdata_c      = wdata;
                rdata_c      = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Single-outstanding load/store unit between the ALU and writeback, with bus timeout.
module lsu_unit
    import lsu_unit_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    lsu_unit_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

    lsu_state_t      state_q, state_d;
    lsu_op_t         op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic            timeout_hit;

    logic            mem_req_valid_q, mem_req_valid_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            mem_wen_q, mem_wen_d;
    logic [3:0]      mem_wmask_q, mem_wmask_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic [4:0]      resp_rd_q, resp_rd_d;
    logic [1:0]      resp_fault_q, resp_fault_d;

    lsu_op_t         align_op;
    logic [3:0]      al_wmask;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            al_misaligned;
    logic            al_illegal;

    // Align unit sees the incoming request in IDLE, the latched one afterwards
    always_comb begin
        if (state_q == LSU_IDLE) begin
            align_op.is_store = bus.req_is_store;
            align_op.funct3   = bus.req_funct3;
            align_op.addr_lo  = bus.req_addr[1:0];
        end else begin
            align_op = op_q;
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .is_store     (align_op.is_store),
        .funct3       (align_op.funct3),
        .addr_lo      (align_op.addr_lo),
        .wdata        (bus.req_wdata),
        .rdata        (bus.mem_rdata),
        .wmask_c      (al_wmask),
        .wdata_c      (al_wdata),
        .rdata_c      (al_rdata),
        .misaligned_c (al_misaligned),
        .illegal_c    (al_illegal)
    );

    // Timeout fires on the cycle the in-flight count would reach TIMEOUT
    always_comb begin
        cnt_inc     = cnt_q + CNT_W'(1);
        timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        cnt_d           = cnt_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        mem_wen_d       = mem_wen_q;
        mem_wmask_d     = mem_wmask_q;
        mem_wdata_d     = mem_wdata_q;
        resp_valid_d    = resp_valid_q;
        resp_data_d     = resp_data_q;
        resp_rd_d       = resp_rd_q;
        resp_fault_d    = resp_fault_q;

        case (state_q)
            LSU_IDLE: begin
                if (bus.req_valid) begin
                    op_d      = align_op;
                    resp_rd_d = bus.req_rd;
                    if (al_illegal || al_misaligned) begin
                        state_d      = LSU_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        resp_fault_d = al_illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
                    end else begin
                        state_d         = LSU_REQ;
                        cnt_d           = '0;
                        mem_req_valid_d = 1'b1;
                        mem_addr_d      = {bus.req_addr[XLEN-1:2], 2'b00};
                        mem_wen_d       = bus.req_is_store;
                        mem_wmask_d     = bus.req_is_store ? al_wmask : 4'b0000;
                        mem_wdata_d     = bus.req_is_store ? al_wdata : '0;
                    end
                end
            end
            LSU_REQ, LSU_WAIT: begin
                cnt_d = cnt_inc;
                if (state_q == LSU_REQ && bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = LSU_WAIT;
                end
                if (bus.mem_rvalid && (state_q == LSU_WAIT || bus.mem_req_ready)) begin
                    state_d      = LSU_RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = FAULT_NONE;
                    resp_data_d  = op_q.is_store ? '0 : al_rdata;
                end else if (timeout_hit &&
                             !(state_q == LSU_REQ && bus.mem_req_ready)) begin
                    state_d         = LSU_RESP;
                    mem_req_valid_d = 1'b0;
                    resp_valid_d    = 1'b1;
                    resp_data_d     = '0;
                    resp_fault_d    = FAULT_BUS;
                end
            end
            LSU_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= LSU_IDLE;
            op_q            <= '0;
            cnt_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wmask_q     <= 4'b0000;
            mem_wdata_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_rd_q       <= 5'd0;
            resp_fault_q    <= FAULT_NONE;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            cnt_q           <= cnt_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_wen_q       <= mem_wen_d;
            mem_wmask_q     <= mem_wmask_d;
            mem_wdata_q     <= mem_wdata_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_rd_q       <= resp_rd_d;
            resp_fault_q    <= resp_fault_d;
        end
    end

    assign bus.req_ready     = (state_q == LSU_IDLE);
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_wmask     = mem_wmask_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_rd       = resp_rd_q;
    assign bus.resp_fault    = resp_fault_q;

endmodule
